muldiv_ctrl: RTL and testbench

//  Sequencer between the execute stage and the multi-cycle mul/div ALU.
//  - Accepts one M-extension op at a time from execute.
//  - Holds operands and the unit's valid stable until data_ok.
//  - Captures the result and holds it until the pipeline consumes it.
//  - Aborts cleanly on pipeline flush and flags a hung unit via a timeout.

---
 rtl/muldiv_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer between the execute stage and the multi-cycle mul/div ALU.
// Accepts one M-extension op at a time. It holds the operands and the unit
// valid stable until the unit reports data_ok. It then holds the result until
// execute consumes it. A flush aborts the op cleanly, and a RUN-cycle timeout
// forces an error completion if the unit hangs.
//
// Optional feature macro: MULDIV_CACHE_EN adds a one-entry result cache.
// An accept that hits the cache completes in one cycle and never starts the unit.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   flush                      kills any in-flight or held op
//   in_valid/in_ready          op handshake from execute (in_func, in_a, in_b)
//   unit_valid                 valid to the ALU (unit_func, unit_a, unit_b)
//   unit_result, unit_data_ok  ALU result and its valid
//   out_valid/out_ready        result handshake to execute (out_result, out_err)
//   busy                       high whenever the sequencer is not idle

package muldiv_pkg;
   typedef logic [63:0] word_t;
   typedef enum logic [3:0] {
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
      ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW
   } alufunc_t;
endpackage

module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 128,
   parameter int CNT_W          = 8
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     flush,
   input  logic     in_valid,
   output logic     in_ready,
   input  alufunc_t in_func,
   input  word_t    in_a,
   input  word_t    in_b,
   output logic     unit_valid,
   output alufunc_t unit_func,
   output word_t    unit_a,
   output word_t    unit_b,
   input  word_t    unit_result,
   input  logic     unit_data_ok,
   output logic     out_valid,
   input  logic     out_ready,
   output word_t    out_result,
   output logic     out_err,
   output logic     busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [CNT_W:0] TIMEOUT_VAL = TIMEOUT_CYCLES[CNT_W:0];

   state_t           state_q, state_d;
   alufunc_t         func_q, func_d;
   word_t            a_q, a_d;
   word_t            b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   word_t            res_q, res_d;
   logic             err_q, err_d;

   logic [CNT_W:0]   cnt_inc;
   logic             timeout_hit;
   logic             cache_hit;
   word_t            cache_res;

   // The counter value after this RUN cycle is compared with the limit.
   // The extra bit keeps the increment from wrapping when cnt_q is all ones.
   // Timeout therefore fires after exactly TIMEOUT_CYCLES RUN cycles.
   assign cnt_inc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc >= TIMEOUT_VAL);

`ifdef MULDIV_CACHE_EN
   logic     cache_vld_q, cache_vld_d;
   alufunc_t cache_func_q, cache_func_d;
   word_t    cache_a_q, cache_a_d;
   word_t    cache_b_q, cache_b_d;
   word_t    cache_res_q, cache_res_d;

   assign cache_hit = cache_vld_q && (cache_func_q == in_func) &&
                      (cache_a_q == in_a) && (cache_b_q == in_b);
   assign cache_res = cache_res_q;

   // Only a genuine unit completion fills the cache. Timeout and flush do not.
   always_comb begin
      cache_vld_d  = cache_vld_q;
      cache_func_d = cache_func_q;
      cache_a_d    = cache_a_q;
      cache_b_d    = cache_b_q;
      cache_res_d  = cache_res_q;
      if (state_q == S_RUN && unit_data_ok && !flush) begin
         cache_vld_d  = 1'b1;
         cache_func_d = func_q;
         cache_a_d    = a_q;
         cache_b_d    = b_q;
         cache_res_d  = unit_result;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cache_vld_q  <= 1'b0;
         cache_func_q <= ALU_MUL;
         cache_a_q    <= '0;
         cache_b_q    <= '0;
         cache_res_q  <= '0;
      end else begin
         cache_vld_q  <= cache_vld_d;
         cache_func_q <= cache_func_d;
         cache_a_q    <= cache_a_d;
         cache_b_q    <= cache_b_d;
         cache_res_q  <= cache_res_d;
      end
   end
`else
   assign cache_hit = 1'b0;
   assign cache_res = '0;
`endif

   always_comb begin
      state_d = state_q;
      func_d  = func_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      err_d   = err_q;
      // Flush outranks data_ok, timeout and out_ready. Any held result is dropped.
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  func_d = in_func;
                  a_d    = in_a;
                  b_d    = in_b;
                  cnt_d  = '0;
                  if (cache_hit) begin
                     res_d   = cache_res;
                     err_d   = 1'b0;
                     state_d = S_DONE;
                  end else begin
                     state_d = S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (unit_data_ok) begin
                  res_d   = unit_result;
                  err_d   = 1'b0;
                  state_d = S_DONE;
               end else if (timeout_hit) begin
                  res_d   = '0;
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else if (!(&cnt_q)) begin
                  cnt_d = cnt_inc[CNT_W-1:0];
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         func_q  <= ALU_MUL;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         func_q  <= func_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign unit_valid = (state_q == S_RUN);
   assign unit_func  = func_q;
   assign unit_a     = a_q;
   assign unit_b     = b_q;
   assign out_valid  = (state_q == S_DONE);
   assign out_result = res_q;
   assign out_err    = err_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   logic     clk = 1'b0;
   logic     reset, flush, in_valid, in_ready, unit_valid, unit_data_ok;
   logic     out_valid, out_ready, out_err, busy;
   alufunc_t in_func, unit_func;
   word_t    in_a, in_b, unit_a, unit_b, unit_result, out_result;

   int vectors = 0;
   int miscompares = 0;
   int lat = 255;      // unit response delay in RUN cycles; 255 = never responds
   int run_cnt = 0;
   logic uv_seen = 1'b0;

   typedef struct {
      word_t res;
      logic  err;
      int    cyc;
   } exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;

   muldiv_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
      .in_a(in_a), .in_b(in_b),
      .unit_valid(unit_valid), .unit_func(unit_func), .unit_a(unit_a), .unit_b(unit_b),
      .unit_result(unit_result), .unit_data_ok(unit_data_ok),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_err(out_err), .busy(busy)
   );

   // Behavioural ALU: computes the result from whatever the sequencer presents.
   function automatic word_t alu_model(alufunc_t f, word_t a, word_t b);
      logic signed [31:0] q32;
      case (f)
         ALU_MUL:  return a * b;
         ALU_DIV:  return (b == 0) ? '1 : word_t'($signed(a) / $signed(b));
         ALU_DIVU: return (b == 0) ? '1 : a / b;
         ALU_REM:  return (b == 0) ? a : word_t'($signed(a) % $signed(b));
         ALU_DIVW: begin
            if (b[31:0] == 32'd0) return '1;
            q32 = $signed(a[31:0]) / $signed(b[31:0]);
            return {{32{q32[31]}}, q32};
         end
         default:  return '0;
      endcase
   endfunction

   assign unit_result  = alu_model(unit_func, unit_a, unit_b);
   assign unit_data_ok = unit_valid && (run_cnt == lat);

   always @(posedge clk) begin
      run_cnt <= unit_valid ? run_cnt + 1 : 0;
   end

   always @(posedge clk) begin
      if (unit_valid) uv_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic do_op(input alufunc_t f, input word_t a, input word_t b, input int l,
                        input word_t er, input logic ee, input int ecyc, input int hold);
      exp_t  e;
      int    cyc;
      word_t first;
      @(negedge clk);
      lat = l;
      uv_seen = 1'b0;
      chk1("in_ready_idle", in_ready, 1'b1);
      in_valid = 1'b1; in_func = f; in_a = a; in_b = b;
      sbq.push_back('{er, ee, ecyc});
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = '1; in_b = '1; in_func = ALU_REMUW;
      cyc = 1;
      if (ecyc > 1) begin
         chk1("in_ready_run", in_ready, 1'b0);
         chk1("unit_valid_run", unit_valid, 1'b1);
         chk("unit_a", unit_a, a);
         chk("unit_b", unit_b, b);
         chk("unit_func", 64'(unit_func), 64'(f));
      end
      while (!out_valid && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      e = sbq.pop_front();
      if (!out_valid) begin
         chk1("out_valid_wait", out_valid, 1'b1);
      end else begin
         chk("latency", 64'(cyc), 64'(e.cyc));
         chk("out_result", out_result, e.res);
         chk1("out_err", out_err, e.err);
         first = out_result;
         repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_result", out_result, first);
            chk1("hold_valid", out_valid, 1'b1);
            chk1("done_unit_valid", unit_valid, 1'b0);
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         chk1("idle_after_ready", busy, 1'b0);
         chk1("out_valid_cleared", out_valid, 1'b0);
      end
      if (ecyc == 1) chk1("unit_never_started", uv_seen, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_func = ALU_MUL; in_a = '0; in_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_unit_valid", unit_valid, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_out_err", out_err, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_unit_a", unit_a, 64'd0);
      reset = 1'b0;

      do_op(ALU_MUL, 64'd3, 64'd5, 2, 64'd15, 1'b0, 4, 0);
      do_op(ALU_DIV, 64'd7, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2, 0);
      do_op(ALU_REM, 64'd7, 64'd0, 0, 64'd7, 1'b0, 2, 0);
      do_op(ALU_DIVW, -64'sd20, 64'd3, 3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 5, 5);

      // Flush in the third RUN cycle of a DIVU that never completes.
      @(negedge clk);
      lat = 255;
      in_valid = 1'b1; in_func = ALU_DIVU; in_a = 64'd100; in_b = 64'd7;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk1("pre_flush_unit_valid", unit_valid, 1'b1);
      flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      chk1("flush_unit_valid", unit_valid, 1'b0);
      chk1("flush_busy", busy, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
         chk1("flush_no_out_valid", out_valid, 1'b0);
      end
      do_op(ALU_MUL, 64'd2, 64'd2, 1, 64'd4, 1'b0, 3, 0);

      // Flush arriving in the same cycle as data_ok wins.
      @(negedge clk);
      lat = 1;
      in_valid = 1'b1; in_func = ALU_DIVU; in_a = 64'd50; in_b = 64'd5;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1;
      chk1("data_ok_with_flush", unit_data_ok, 1'b1);
      flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      chk1("flush_beats_data_ok", out_valid, 1'b0);
      chk1("flush_beats_data_ok_busy", busy, 1'b0);

      // Hung unit: error completion after 16 RUN cycles.
      do_op(ALU_MUL, 64'd9, 64'd9, 255, 64'd0, 1'b1, 17, 0);

`ifdef MULDIV_CACHE_EN
      do_op(ALU_MUL, 64'd6, 64'd7, 3, 64'd42, 1'b0, 5, 0);
      do_op(ALU_MUL, 64'd6, 64'd7, 3, 64'd42, 1'b0, 1, 0);
`else
      do_op(ALU_MUL, 64'd6, 64'd7, 3, 64'd42, 1'b0, 5, 0);
      do_op(ALU_MUL, 64'd6, 64'd7, 3, 64'd42, 1'b0, 5, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
